// File: rtl/uart_b3.sv
// rtl/uart_b3.sv - memory-mapped 8N1 UART with TX/RX FIFOs
// Define UART_LOOPBACK_EN to add CTRL (0x04) with internal tx->rx loopback.
module uart_b3 #(
  parameter int CLK_HZ  = 100000000,
  parameter int BAUD    = 115200,
  parameter int FIFO_AW = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] addr,
  output logic [7:0] dout,
  input  logic [7:0] din,
  input  logic       re,
  input  logic       we,
  output logic       tx,
  input  logic       rx
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] DIV_RST = 16'(CLK_HZ / BAUD - 1);
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [15:0] div_q, div_eff;
  logic        rx_ovr, frm_err, tx_ovf, loop;
  logic [7:0]  tx_mem [DEPTH];
  logic [7:0]  rx_mem [DEPTH];
  logic [FIFO_AW:0] tx_wp, tx_rp, rx_wp, rx_rp;
  logic tx_empty, tx_full, rx_empty, rx_full;

  state_t      tx_state, rx_state;
  logic        tx_q;
  logic [15:0] tx_cnt, tx_div, rx_cnt, rx_div, rx_h, rx_h_m1;
  logic [2:0]  tx_bit, rx_bit;
  logic [7:0]  tx_shift, rx_shift;
  logic        rx_in, rx_s1, rx_s2, rx_prev;

  logic wr_data, wr_stat, rd_data, tx_pop, tx_push, rx_stop_smp, rx_push, rx_ovr_set, frm_set, tx_ovf_set;

  assign div_eff  = (div_q == 16'd0) ? 16'd1 : div_q;
  assign tx_empty = (tx_wp == tx_rp);
  assign tx_full  = (tx_wp[FIFO_AW] != tx_rp[FIFO_AW]) && (tx_wp[FIFO_AW-1:0] == tx_rp[FIFO_AW-1:0]);
  assign rx_empty = (rx_wp == rx_rp);
  assign rx_full  = (rx_wp[FIFO_AW] != rx_rp[FIFO_AW]) && (rx_wp[FIFO_AW-1:0] == rx_rp[FIFO_AW-1:0]);

  assign wr_data = we && (addr == 8'h00);
  assign wr_stat = we && (addr == 8'h01);
  assign rd_data = re && (addr == 8'h00) && !rx_empty;

  // Same-edge pop frees a slot, so a push into a full FIFO is still accepted.
  assign tx_pop      = !tx_empty && ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == tx_div));
  assign tx_push     = wr_data && (!tx_full || tx_pop);
  assign tx_ovf_set  = wr_data && tx_full && !tx_pop;
  assign rx_stop_smp = (rx_state == S_STOP) && (rx_cnt == rx_div);
  assign rx_push     = rx_stop_smp && rx_s2 && (!rx_full || rd_data);
  assign rx_ovr_set  = rx_stop_smp && rx_s2 && rx_full && !rd_data;
  assign frm_set     = rx_stop_smp && !rx_s2;

  assign rx_h    = {1'b0, rx_div[15:1]} + {15'd0, rx_div[0]};
  assign rx_h_m1 = rx_h - 16'd1;

`ifdef UART_LOOPBACK_EN
  assign rx_in = loop ? tx_q : rx;
  assign tx    = loop ? 1'b1 : tx_q;
`else
  assign rx_in = rx;
  assign tx    = tx_q;
  assign loop  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp[FIFO_AW-1:0]] <= din;
    if (rx_push) rx_mem[rx_wp[FIFO_AW-1:0]] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q   <= DIV_RST;
      tx_wp   <= '0;
      tx_rp   <= '0;
      rx_wp   <= '0;
      rx_rp   <= '0;
      rx_ovr  <= 1'b0;
      frm_err <= 1'b0;
      tx_ovf  <= 1'b0;
`ifdef UART_LOOPBACK_EN
      loop    <= 1'b0;
`endif
    end else begin
      if (tx_push) tx_wp <= tx_wp + PTR_ONE;
      if (tx_pop)  tx_rp <= tx_rp + PTR_ONE;
      if (rx_push) rx_wp <= rx_wp + PTR_ONE;
      if (rd_data) rx_rp <= rx_rp + PTR_ONE;
      rx_ovr  <= (rx_ovr  & ~(wr_stat & din[4])) | rx_ovr_set;
      frm_err <= (frm_err & ~(wr_stat & din[5])) | frm_set;
      tx_ovf  <= (tx_ovf  & ~(wr_stat & din[6])) | tx_ovf_set;
      if (we && addr == 8'h02) div_q[7:0]  <= din;
      if (we && addr == 8'h03) div_q[15:8] <= din;
`ifdef UART_LOOPBACK_EN
      if (we && addr == 8'h04) loop <= din[0];
`endif
    end
  end

  // TX: divisor is captured at each frame start so mid-frame DIV writes wait.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state <= S_IDLE;
      tx_q     <= 1'b1;
      tx_cnt   <= '0;
      tx_div   <= 16'd1;
      tx_bit   <= '0;
      tx_shift <= '0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_pop) begin
          tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
          tx_div   <= div_eff;
          tx_cnt   <= '0;
          tx_q     <= 1'b0;
          tx_state <= S_START;
        end
        S_START: if (tx_cnt == tx_div) begin
          tx_cnt   <= '0;
          tx_bit   <= '0;
          tx_q     <= tx_shift[0];
          tx_state <= S_DATA;
        end else tx_cnt <= tx_cnt + 16'd1;
        S_DATA: if (tx_cnt == tx_div) begin
          tx_cnt <= '0;
          if (tx_bit == 3'd7) begin
            tx_q     <= 1'b1;
            tx_state <= S_STOP;
          end else begin
            tx_bit   <= tx_bit + 3'd1;
            tx_shift <= tx_shift >> 1;
            tx_q     <= tx_shift[1];
          end
        end else tx_cnt <= tx_cnt + 16'd1;
        default: if (tx_cnt == tx_div) begin
          tx_cnt <= '0;
          if (tx_pop) begin
            tx_shift <= tx_mem[tx_rp[FIFO_AW-1:0]];
            tx_div   <= div_eff;
            tx_q     <= 1'b0;
            tx_state <= S_START;
          end else tx_state <= S_IDLE;
        end else tx_cnt <= tx_cnt + 16'd1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_div   <= 16'd1;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        S_IDLE: if (!rx_s2 && rx_prev) begin
          rx_div   <= div_eff;
          rx_cnt   <= '0;
          rx_state <= S_START;
        end
        S_START: if (rx_cnt == rx_h_m1) begin
          rx_cnt   <= '0;
          rx_bit   <= '0;
          rx_state <= rx_s2 ? S_IDLE : S_DATA;
        end else rx_cnt <= rx_cnt + 16'd1;
        S_DATA: if (rx_cnt == rx_div) begin
          rx_cnt   <= '0;
          rx_shift <= {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) rx_state <= S_STOP;
          else rx_bit <= rx_bit + 3'd1;
        end else rx_cnt <= rx_cnt + 16'd1;
        default: if (rx_cnt == rx_div) begin
          rx_cnt   <= '0;
          rx_state <= S_IDLE;
        end else rx_cnt <= rx_cnt + 16'd1;
      endcase
    end
  end

  always_comb begin
    dout = 8'h00;
    case (addr)
      8'h00: dout = rx_empty ? 8'h00 : rx_mem[rx_rp[FIFO_AW-1:0]];
      8'h01: dout = {1'b0, tx_ovf, frm_err, rx_ovr, (tx_empty && tx_state == S_IDLE), tx_full, rx_full, !rx_empty};
      8'h02: dout = div_q[7:0];
      8'h03: dout = div_q[15:8];
      8'h04: dout = {7'd0, loop};
      default: dout = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_b3.sv
// tb/tb_uart_b3.sv - directed self-checking bench for uart_b3
module tb_uart_b3;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       re = 1'b0;
  logic       we = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] dout;
  logic       tx;

  int errors = 0;
  int checks = 0;

  uart_b3 dut (
    .clk(clk), .reset_n(reset_n), .addr(addr), .dout(dout), .din(din),
    .re(re), .we(we), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    @(negedge clk);
    addr = a; din = v; we = 1'b1;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    @(negedge clk);
    addr = a; re = 1'b1;
    #1 v = dout;
    @(negedge clk);
    re = 1'b0;
  endtask

  // DIV=3: every serial bit lasts 4 clock cycles.
  task automatic send_frame(input logic [7:0] v, input logic stop);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = v[i];
      repeat (4) @(negedge clk);
    end
    rx = stop;
    repeat (4) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx); end
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL reset_stat got=%h exp=08", d); end
    rd(8'h02, d);
    checks++; if (d !== 8'h63) begin errors++; $display("FAIL reset_divl got=%h exp=63", d); end
    rd(8'h03, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL reset_divh got=%h exp=03", d); end
    rd(8'h04, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", d); end
  endtask

  task automatic test_regs;
    logic [7:0] d;
    wr(8'h02, 8'h03);
    wr(8'h03, 8'h00);
    rd(8'h02, d);
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL divl_rw got=%h exp=03", d); end
    rd(8'h03, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL divh_rw got=%h exp=00", d); end
    @(negedge clk);
    addr = 8'h02; din = 8'h07; re = 1'b1; we = 1'b1;
    #1 d = dout;
    @(negedge clk);
    re = 1'b0; we = 1'b0;
    checks++; if (d !== 8'h03) begin errors++; $display("FAIL rw_same_read got=%h exp=03", d); end
    rd(8'h02, d);
    checks++; if (d !== 8'h07) begin errors++; $display("FAIL rw_same_write got=%h exp=07", d); end
    wr(8'h02, 8'h03);
    wr(8'h05, 8'hFF);
    rd(8'h05, d);
    checks++; if (d !== 8'h00) begin errors++; $display("FAIL unmapped got=%h exp=00", d); end
  endtask

  task automatic test_tx_frame;
    logic [7:0] d;
    logic [9:0] exp_bits;
    logic       found;
    exp_bits = {1'b1, 8'hA5, 1'b0};
    found = 1'b0;
    wr(8'h00, 8'hA5);
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (tx === 1'b0) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL tx_start_timeout got=%b exp=0", tx); end
    if (found) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (tx !== exp_bits[i]) begin errors++; $display("FAIL tx_bit%0d got=%b exp=%b", i, tx, exp_bits[i]); end
        repeat (4) @(negedge clk);
      end
    end
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL tx_idle_stat got=%h exp=08", d); end
  endtask

  task automatic test_tx_overflow;
    logic [7:0] d;
    logic       idle;
    for (int i = 0; i < 18; i++) wr(8'h00, 8'h10 + 8'(i));
    rd(8'h01, d);
    checks++; if (d !== 8'h44) begin errors++; $display("FAIL tx_ovf_stat got=%h exp=44", d); end
    wr(8'h01, 8'h40);
    rd(8'h01, d);
    checks++; if (d[6] !== 1'b0) begin errors++; $display("FAIL tx_ovf_clear got=%b exp=0", d[6]); end
    idle = 1'b0;
    for (int k = 0; k < 100 && !idle; k++) begin
      repeat (10) @(negedge clk);
      rd(8'h01, d);
      if (d === 8'h08) idle = 1'b1;
    end
    checks++; if (!idle) begin errors++; $display("FAIL tx_drain_timeout got=%h exp=08", d); end
  endtask

  task automatic test_rx;
    logic [7:0] d;
    send_frame(8'h3C, 1'b1);
    repeat (4) @(negedge clk);
    rd(8'h01, d);
    checks++; if (d !== 8'h09) begin errors++; $display("FAIL rx_ne got=%h exp=09", d); end
    rd(8'h00, d);
    checks++; if (d !== 8'h3C) begin errors++; $display("FAIL rx_data got=%h exp=3c", d); end
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL rx_empty got=%h exp=08", d); end
  endtask

  task automatic test_rx_errors;
    logic [7:0] d;
    send_frame(8'h55, 1'b0);
    repeat (4) @(negedge clk);
    rd(8'h01, d);
    checks++; if (d !== 8'h28) begin errors++; $display("FAIL frm_err got=%h exp=28", d); end
    wr(8'h01, 8'h20);
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL frm_clear got=%h exp=08", d); end
    @(negedge clk);
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL glitch got=%h exp=08", d); end
    for (int i = 0; i < 17; i++) send_frame(8'h40 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    rd(8'h01, d);
    checks++; if (d !== 8'h1B) begin errors++; $display("FAIL rx_ovr got=%h exp=1b", d); end
    rd(8'h00, d);
    checks++; if (d !== 8'h40) begin errors++; $display("FAIL rx_first got=%h exp=40", d); end
    rd(8'h01, d);
    checks++; if (d !== 8'h19) begin errors++; $display("FAIL rx_after_pop got=%h exp=19", d); end
    for (int i = 1; i < 16; i++) begin
      rd(8'h00, d);
      checks++;
      if (d !== 8'h40 + 8'(i)) begin errors++; $display("FAIL rx_drain%0d got=%h exp=%h", i, d, 8'h40 + 8'(i)); end
    end
    wr(8'h01, 8'h10);
    rd(8'h01, d);
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL rx_ovr_clear got=%h exp=08", d); end
  endtask

`ifdef UART_LOOPBACK_EN
  task automatic test_loopback;
    logic [7:0] d;
    logic       held;
    wr(8'h04, 8'h01);
    rd(8'h04, d);
    checks++; if (d !== 8'h01) begin errors++; $display("FAIL ctrl_rw got=%h exp=01", d); end
    held = 1'b1;
    wr(8'h00, 8'h5A);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (tx !== 1'b1) held = 1'b0;
    end
    checks++; if (!held) begin errors++; $display("FAIL loop_tx_pin got=0 exp=1"); end
    rd(8'h00, d);
    checks++; if (d !== 8'h5A) begin errors++; $display("FAIL loop_data got=%h exp=5a", d); end
    wr(8'h04, 8'h00);
  endtask
`endif

  initial begin
    test_reset();
    test_regs();
    test_tx_frame();
    test_tx_overflow();
    test_rx();
    test_rx_errors();
`ifdef UART_LOOPBACK_EN
    test_loopback();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
